// File: rtl/alu64.sv
// Registered 64-bit ALU (ADD/SUB/AND/OR/XOR, optional signed MUL/DIV via ALU_MULDIV_EN); 1-cycle latency.
// One op per cycle with no handshake and no backpressure; synchronous active-high reset.
module alu64 #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALUop,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_hi,
   output logic [WIDTH-1:0] REM,
   output logic             ZERO,
   output logic             COUT,
   output logic             OVF,
   output logic             DIV0
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
`ifdef ALU_MULDIV_EN
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_DIV = 3'b110;
`endif

   logic [WIDTH-1:0] y_d;
   logic [WIDTH-1:0] y_hi_d;
   logic [WIDTH-1:0] rem_d;
   logic             cout_d;
   logic             ovf_d;
   logic             div0_d;

   // Bit WIDTH of diff is the borrow out of the subtraction.
   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;
   assign sum  = {1'b0, A} + {1'b0, B};
   assign diff = {1'b0, A} - {1'b0, B};

`ifdef ALU_MULDIV_EN
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] prod;
   logic signed [WIDTH-1:0]   quot;
   logic signed [WIDTH-1:0]   rmd;
   logic                      div_ovf;

   assign prod    = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
   assign div_ovf = (A == SMIN) && (B == {WIDTH{1'b1}});

   // Divider inputs are gated so the two undefined cases never reach the operator.
   always_comb begin
      quot = '0;
      rmd  = '0;
      if ((B != '0) && !div_ovf) begin
         quot = $signed(A) / $signed(B);
         rmd  = $signed(A) % $signed(B);
      end
   end
`endif

   always_comb begin
      y_d    = '0;
      y_hi_d = '0;
      rem_d  = '0;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
      div0_d = 1'b0;
      case (ALUop)
         OP_ADD: begin
            y_d    = sum[WIDTH-1:0];
            cout_d = sum[WIDTH];
            ovf_d  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            y_d    = diff[WIDTH-1:0];
            cout_d = ~diff[WIDTH];
            ovf_d  = (A[WIDTH-1] ^ B[WIDTH-1]) & (A[WIDTH-1] ^ diff[WIDTH-1]);
         end
         OP_AND: y_d = A & B;
         OP_OR:  y_d = A | B;
         OP_XOR: y_d = A ^ B;
`ifdef ALU_MULDIV_EN
         OP_MUL: begin
            y_d    = prod[WIDTH-1:0];
            y_hi_d = prod[2*WIDTH-1:WIDTH];
         end
         OP_DIV: begin
            if (B == '0) begin
               div0_d = 1'b1;
            end else if (div_ovf) begin
               y_d   = SMIN;
               ovf_d = 1'b1;
            end else begin
               y_d   = quot;
               rem_d = rmd;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Y    <= '0;
         Y_hi <= '0;
         REM  <= '0;
         ZERO <= 1'b1;
         COUT <= 1'b0;
         OVF  <= 1'b0;
         DIV0 <= 1'b0;
      end else begin
         Y    <= y_d;
         Y_hi <= y_hi_d;
         REM  <= rem_d;
         ZERO <= (y_d == '0);
         COUT <= cout_d;
         OVF  <= ovf_d;
         DIV0 <= div0_d;
      end
   end

endmodule

// File: tb/tb_alu64.sv
// Self-checking bench for alu64: directed vectors, randomized ops against a reference model, pipelining and reset.
module tb_alu64;

   typedef struct packed {
      logic [63:0] y;
      logic [63:0] y_hi;
      logic [63:0] rem;
      logic        zero;
      logic        cout;
      logic        ovf;
      logic        div0;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] A = '0;
   logic [63:0] B = '0;
   logic [2:0]  ALUop = '0;
   logic [63:0] Y, Y_hi, REM;
   logic        ZERO, COUT, OVF, DIV0;
   res_t        obs;

   int checks = 0;
   int errors = 0;

   alu64 #(.WIDTH(64)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .ALUop(ALUop),
      .Y(Y), .Y_hi(Y_hi), .REM(REM),
      .ZERO(ZERO), .COUT(COUT), .OVF(OVF), .DIV0(DIV0)
   );

   always #5 clk = ~clk;
   assign obs = {Y, Y_hi, REM, ZERO, COUT, OVF, DIV0};

   localparam res_t RST_VAL = '{y: '0, y_hi: '0, rem: '0, zero: 1'b1, cout: 1'b0, ovf: 1'b0, div0: 1'b0};

   // Reference model: works from numeric meaning (signed ranges, magnitudes), not from bit-level formulas.
   function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
      res_t r;
      logic [64:0] s;
      logic signed [65:0] wide;
      logic signed [127:0] ea, eb, p;
      logic [63:0] ua, ub, q, rm;
      r = RST_VAL;
      r.zero = 1'b0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r.y = s[63:0];
            r.cout = s[64];
            wide = 66'($signed(a)) + 66'($signed(b));
            r.ovf = (wide > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -66'sh0_8000_0000_0000_0000);
         end
         3'd1: begin
            r.y = a - b;
            r.cout = (a >= b);
            wide = 66'($signed(a)) - 66'($signed(b));
            r.ovf = (wide > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -66'sh0_8000_0000_0000_0000);
         end
         3'd2: r.y = a & b;
         3'd3: r.y = a | b;
         3'd4: r.y = a ^ b;
`ifdef ALU_MULDIV_EN
         3'd5: begin
            ea = 128'($signed(a));
            eb = 128'($signed(b));
            p = ea * eb;
            r.y = p[63:0];
            r.y_hi = p[127:64];
         end
         3'd6: begin
            if (b == 0) begin
               r.div0 = 1'b1;
            end else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
               r.y = a;
               r.ovf = 1'b1;
            end else begin
               ua = a[63] ? -a : a;
               ub = b[63] ? -b : b;
               q = ua / ub;
               rm = ua % ub;
               r.y = (a[63] ^ b[63]) ? -q : q;
               r.rem = a[63] ? -rm : rm;
            end
         end
`endif
         default: ;
      endcase
      r.zero = (r.y == 0);
      return r;
   endfunction

   task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
      @(negedge clk);
      A = a; B = b; ALUop = op;
      @(negedge clk);
   endtask

   function automatic logic [63:0] rnd_operand();
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0: v = 64'($urandom_range(0, 20));
         1: v = -64'($urandom_range(1, 20));
         2: v = 64'h8000_0000_0000_0000;
         3: v = 64'h7FFF_FFFF_FFFF_FFFF;
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      A = 64'h1234; B = 64'h5678; ALUop = 3'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (obs !== RST_VAL) begin
         errors++;
         $display("FAIL reset: got %h expected %h", obs, RST_VAL);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed_alu();
      logic [63:0] av[7], bv[7];
      logic [2:0]  ov[7];
      res_t        ev[7];
      av[0] = 64'hAAAA_AAAA_AAAA_AAAA; bv[0] = 64'h5555_5555_5555_5555; ov[0] = 3'd0;
      ev[0] = '{y: 64'hFFFF_FFFF_FFFF_FFFF, y_hi: '0, rem: '0, zero: 0, cout: 0, ovf: 0, div0: 0};
      av[1] = 64'hFFFF_FFFF_FFFF_FFFF; bv[1] = 64'h1; ov[1] = 3'd0;
      ev[1] = '{y: 64'h0, y_hi: '0, rem: '0, zero: 1, cout: 1, ovf: 0, div0: 0};
      av[2] = 64'hAAAA_AAAA_AAAA_AAAA; bv[2] = 64'h5555_5555_5555_5555; ov[2] = 3'd1;
      ev[2] = '{y: 64'h5555_5555_5555_5555, y_hi: '0, rem: '0, zero: 0, cout: 1, ovf: 1, div0: 0};
      av[3] = 64'h1; bv[3] = 64'h2; ov[3] = 3'd1;
      ev[3] = '{y: 64'hFFFF_FFFF_FFFF_FFFF, y_hi: '0, rem: '0, zero: 0, cout: 0, ovf: 0, div0: 0};
      av[4] = 64'hF0F0_F0F0_F0F0_F0F0; bv[4] = 64'h0F0F_0F0F_0F0F_0F0F; ov[4] = 3'd2;
      ev[4] = '{y: 64'h0, y_hi: '0, rem: '0, zero: 1, cout: 0, ovf: 0, div0: 0};
      av[5] = 64'h0123_4567_89AB_CDEF; bv[5] = 64'h1111_1111_1111_1111; ov[5] = 3'd3;
      ev[5] = '{y: 64'h1133_5577_99BB_DDFF, y_hi: '0, rem: '0, zero: 0, cout: 0, ovf: 0, div0: 0};
      av[6] = 64'hF0F0_F0F0_F0F0_F0F0; bv[6] = 64'h0FF0_0FF0_0FF0_0FF0; ov[6] = 3'd4;
      ev[6] = '{y: 64'hFF00_FF00_FF00_FF00, y_hi: '0, rem: '0, zero: 0, cout: 0, ovf: 0, div0: 0};
      for (int i = 0; i < 7; i++) begin
         apply(av[i], bv[i], ov[i]);
         checks++;
         if (obs !== ev[i]) begin
            errors++;
            $display("FAIL alu_vec%0d op=%0d: got %h expected %h", i, ov[i], obs, ev[i]);
         end
      end
   endtask

   task automatic test_muldiv();
      logic [63:0] av[7], bv[7];
      logic [2:0]  ov[7];
      res_t        ev[7];
      av[0] = 64'd20000; bv[0] = 64'd20000; ov[0] = 3'd5;
      av[1] = -64'd1;    bv[1] = 64'd2;     ov[1] = 3'd5;
      av[2] = 64'd20;    bv[2] = 64'd6;     ov[2] = 3'd6;
      av[3] = -64'd7;    bv[3] = 64'd2;     ov[3] = 3'd6;
      av[4] = 64'd1234;  bv[4] = 64'd0;     ov[4] = 3'd6;
      av[5] = 64'h8000_0000_0000_0000; bv[5] = -64'd1; ov[5] = 3'd6;
      av[6] = 64'h1234;  bv[6] = 64'h5678;  ov[6] = 3'd7;
      for (int i = 0; i < 7; i++) ev[i] = RST_VAL;
`ifdef ALU_MULDIV_EN
      ev[0].y = 64'h17D7_8400; ev[0].zero = 0;
      ev[1].y = 64'hFFFF_FFFF_FFFF_FFFE; ev[1].y_hi = 64'hFFFF_FFFF_FFFF_FFFF; ev[1].zero = 0;
      ev[2].y = 64'd3; ev[2].rem = 64'd2; ev[2].zero = 0;
      ev[3].y = 64'hFFFF_FFFF_FFFF_FFFD; ev[3].rem = 64'hFFFF_FFFF_FFFF_FFFF; ev[3].zero = 0;
      ev[4].div0 = 1;
      ev[5].y = 64'h8000_0000_0000_0000; ev[5].ovf = 1; ev[5].zero = 0;
`endif
      for (int i = 0; i < 7; i++) begin
         apply(av[i], bv[i], ov[i]);
         checks++;
         if (obs !== ev[i]) begin
            errors++;
            $display("FAIL muldiv_vec%0d op=%0d: got %h expected %h", i, ov[i], obs, ev[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] a, b;
      logic [2:0]  op;
      res_t        e;
      for (int i = 0; i < 300; i++) begin
         a = rnd_operand();
         b = rnd_operand();
         op = 3'($urandom_range(0, 7));
         e = model(a, b, op);
         apply(a, b, op);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL random%0d op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, obs, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      res_t        q[$];
      res_t        e;
      logic [63:0] a, b;
      logic [2:0]  op;
      for (int i = 0; i < 41; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL b2b%0d: got %h expected %h", i, obs, e);
            end
         end
         a = rnd_operand();
         b = rnd_operand();
         op = 3'($urandom_range(0, 7));
         A = a; B = b; ALUop = op;
         q.push_back(model(a, b, op));
      end
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      A = 64'd20000; B = 64'd20000; ALUop = 3'd5;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== RST_VAL) begin
         errors++;
         $display("FAIL reset_midop: got %h expected %h", obs, RST_VAL);
      end
      // First result after release must come from the op sampled on the following edge.
      A = 64'd5; B = 64'd7; ALUop = 3'd0;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== model(64'd5, 64'd7, 3'd0)) begin
         errors++;
         $display("FAIL reset_release: got %h expected %h", obs, model(64'd5, 64'd7, 3'd0));
      end
   endtask

   initial begin
      test_reset();
      test_directed_alu();
      test_muldiv();
      test_random();
      test_back_to_back();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
